// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundles the two requester ports (CPU, DMA/loader) and the
//               memory-side control bus of mem_bus_arbiter.
//               The arbiter owns the memory bus, so it takes the "master"
//               modport. Requesters and the memory take the "slave" view.
//               The bidirectional data bus dx is not carried here; it stays
//               a plain inout net on the arbiter.
// Ports       : cpu_*  - CPU request/response channel
//               dma_*  - DMA/loader request/response channel
//               ax, ema, cpmem, mrd, mwr, dma_active - memory cycle control
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if;
  // CPU channel
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_cp;
  logic [2:0]  cpu_ema;
  logic [11:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_lock;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  // DMA channel
  logic        dma_req;
  logic        dma_we;
  logic        dma_cp;
  logic [2:0]  dma_ema;
  logic [11:0] dma_addr;
  logic [11:0] dma_wdata;
  logic        dma_ack;
  logic [11:0] dma_rdata;
  // Memory cycle control
  logic [11:0] ax;
  logic [2:0]  ema;
  logic        cpmem;
  logic        mrd;
  logic        mwr;
  logic        dma_active;

  modport master (
    input  cpu_req, cpu_we, cpu_cp, cpu_ema, cpu_addr, cpu_wdata, cpu_lock,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_cp, dma_ema, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output ax, ema, cpmem, mrd, mwr, dma_active
  );

  modport slave (
    output cpu_req, cpu_we, cpu_cp, cpu_ema, cpu_addr, cpu_wdata, cpu_lock,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_cp, dma_ema, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  ax, ema, cpmem, mrd, mwr, dma_active
  );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Two-way memory arbiter (CPU vs. DMA/loader). Runs one memory
//               cycle per grant: IDLE -> ACC_x (one strobe cycle) -> ACK
//               (one-cycle ack with read data) -> IDLE.
//               DMA has priority, limited by a burst guard (at most DMA_BURST
//               consecutive DMA grants while the CPU waits) and by a CPU lock
//               that reserves the next grant for the CPU (RMW instructions).
// Ports       : cpuclk  - clock, all state on rising edge
//               reset   - asynchronous active-high reset
//               bus     - requester channels + memory control (master view)
//               dx      - shared 12-bit memory data bus (driven on writes)
// Parameters  : DMA_BURST - DMA grant quota while cpu_req is pending (1..15)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int DMA_BURST = 4
) (
  input  wire               cpuclk,
  input  wire               reset,
  mem_bus_arbiter_if.master bus,
  inout  wire [11:0]        dx
);

  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_DMA = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      state;
  logic        lock;
  logic [3:0]  burst;
  logic [11:0] ax_q;
  logic [2:0]  ema_q;
  logic        cpmem_q;
  logic        mrd_q;
  logic        mwr_q;
  logic [11:0] wdata_q;
  logic        cpu_ack_q;
  logic        dma_ack_q;
  logic [11:0] cpu_rdata_q;
  logic [11:0] dma_rdata_q;
  logic        dma_active_q;

  // Arbitration terms, only acted on in IDLE.
  logic lock_win;
  logic dma_win;
  logic cpu_win;

  assign lock_win = lock && bus.cpu_req;
  // DMA loses only when the CPU has already waited out a full burst.
  assign dma_win  = !lock_win && bus.dma_req && !(bus.cpu_req && (burst == BURST_MAX));
  assign cpu_win  = !lock_win && !dma_win && bus.cpu_req;

  always_ff @(posedge cpuclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lock         <= 1'b0;
      burst        <= '0;
      ax_q         <= '0;
      ema_q        <= '0;
      cpmem_q      <= 1'b0;
      mrd_q        <= 1'b0;
      mwr_q        <= 1'b0;
      wdata_q      <= '0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      dma_active_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Burst only counts DMA grants taken while the CPU is waiting.
          if (!bus.cpu_req) begin
            burst <= '0;
          end else if (dma_win) begin
            if (burst != 4'hF) burst <= burst + 4'd1;
          end else if (cpu_win) begin
            burst <= '0;
          end

          if (lock_win || cpu_win) begin
            state        <= ACC_CPU;
            ax_q         <= bus.cpu_addr;
            ema_q        <= bus.cpu_ema;
            cpmem_q      <= bus.cpu_cp;
            mrd_q        <= ~bus.cpu_we;
            mwr_q        <= bus.cpu_we;
            wdata_q      <= bus.cpu_wdata;
            lock         <= bus.cpu_lock;
            dma_active_q <= 1'b0;
          end else if (dma_win) begin
            state        <= ACC_DMA;
            ax_q         <= bus.dma_addr;
            ema_q        <= bus.dma_ema;
            cpmem_q      <= bus.dma_cp;
            mrd_q        <= ~bus.dma_we;
            mwr_q        <= bus.dma_we;
            wdata_q      <= bus.dma_wdata;
            dma_active_q <= 1'b1;
          end
        end

        ACC_CPU, ACC_DMA: begin
          // Memory has had the whole cycle to drive dx for a read.
          if (mrd_q) begin
            if (state == ACC_DMA) dma_rdata_q <= dx;
            else                  cpu_rdata_q <= dx;
          end
          cpu_ack_q <= (state == ACC_CPU);
          dma_ack_q <= (state == ACC_DMA);
          mrd_q     <= 1'b0;
          mwr_q     <= 1'b0;
          state     <= ACK;
        end

        ACK: begin
          cpu_ack_q    <= 1'b0;
          dma_ack_q    <= 1'b0;
          dma_active_q <= 1'b0;
          state        <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Data bus is driven only during the write strobe.
  assign dx = mwr_q ? wdata_q : 12'bz;

  assign bus.ax         = ax_q;
  assign bus.ema        = ema_q;
  assign bus.cpmem      = cpmem_q;
  assign bus.mrd        = mrd_q;
  assign bus.mwr        = mwr_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dma_rdata  = dma_rdata_q;
  assign bus.dma_active = dma_active_q;

endmodule
`default_nettype wire
